// File: rtl/conv2d_sched.sv
// conv2d_sched: layer-level scheduler for a 2-D convolution engine.
//
// A layer is a set of passes, one for each (output channel, input channel)
// pair. The input channel index (ic) steps fastest. Each pass runs in this
// order:
//   1. Request a KS*KS weight load (param_prefetch).
//   2. Wait for wload_done.
//   3. Start the pass (param_ena).
//   4. Wait for pass_done.
//   5. Advance to the next (ic, oc) pair.
//
// The weight, input-plane and output-plane addresses are kept as running sums
// (no multipliers).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cfg_start, cfg_abort  one-cycle layer start / abort pulses
//   cfg_waddr/xaddr/yaddr base addresses (weights, input planes, output planes)
//   cfg_xstride/ystride   byte stride between input / output planes
//   cfg_width_in, cfg_length_in, cfg_length_out  per-pass geometry (passed through)
//   cfg_num_ic, cfg_num_oc                       channel counts
//   cfg_busy, cfg_done                           layer status
//   param_prefetch, param_waddr, param_length_w  weight-load request
//   param_ena, param_xaddr, param_yaddr, param_width_in,
//   param_length_in, param_length_out            pass-start request
//   wload_done, pass_done                        completion handshakes
module conv2d_sched #(
  parameter int KS = 3,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_start,
  input  logic          cfg_abort,
  input  logic [AW-1:0] cfg_waddr,
  input  logic [AW-1:0] cfg_xaddr,
  input  logic [AW-1:0] cfg_yaddr,
  input  logic [AW-1:0] cfg_xstride,
  input  logic [AW-1:0] cfg_ystride,
  input  logic [8:0]    cfg_width_in,
  input  logic [17:0]   cfg_length_in,
  input  logic [17:0]   cfg_length_out,
  input  logic [7:0]    cfg_num_ic,
  input  logic [7:0]    cfg_num_oc,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          param_prefetch,
  output logic [AW-1:0] param_waddr,
  output logic [7:0]    param_length_w,
  output logic          param_ena,
  output logic [AW-1:0] param_xaddr,
  output logic [AW-1:0] param_yaddr,
  output logic [8:0]    param_width_in,
  output logic [17:0]   param_length_in,
  output logic [17:0]   param_length_out,
  input  logic          wload_done,
  input  logic          pass_done
);

  // Consecutive passes are one weight block apart in memory, so the weight
  // address advances by a fixed byte step on every pass.
  localparam logic [AW-1:0] W_STEP = AW'(KS * KS * 4);
  localparam logic [7:0]    LEN_W  = 8'(KS * KS);

  typedef enum logic [6:0] {
    S_IDLE   = 7'b0000001,
    S_LOAD_W = 7'b0000010,
    S_WAIT_W = 7'b0000100,
    S_RUN    = 7'b0001000,
    S_WAIT_P = 7'b0010000,
    S_NEXT   = 7'b0100000,
    S_DONE   = 7'b1000000
  } state_t;

  state_t state, state_nx;

  logic [7:0]    ic, oc;
  logic [7:0]    num_ic, num_oc;
  logic [AW-1:0] x_base, xstride, ystride;
  logic          more_passes;

  logic accept, advance, ic_last, oc_last, zero_layer;

  assign accept     = (state == S_IDLE) && cfg_start;
  // An abort that coincides with pass_done suppresses the address advance.
  assign advance    = (state == S_WAIT_P) && pass_done && !cfg_abort;
  assign ic_last    = (ic == num_ic - 8'd1);
  assign oc_last    = (oc == num_oc - 8'd1);
  assign zero_layer = (cfg_num_ic == 8'd0) || (cfg_num_oc == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Strobes and status come straight from the one-hot state bits, so they
  // are glitch-free and exactly one cycle wide.
  always_comb begin
    state_nx       = state;
    cfg_busy       = (state != S_IDLE);
    cfg_done       = (state == S_DONE);
    param_prefetch = (state == S_LOAD_W);
    param_ena      = (state == S_RUN);
    unique case (state)
      S_IDLE:   if (cfg_start) state_nx = zero_layer ? S_DONE : S_LOAD_W;
      S_LOAD_W: state_nx = S_WAIT_W;
      S_WAIT_W: if (wload_done) state_nx = S_RUN;
      S_RUN:    state_nx = S_WAIT_P;
      S_WAIT_P: if (pass_done) state_nx = S_NEXT;
      S_NEXT:   state_nx = more_passes ? S_LOAD_W : S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (cfg_abort && (state != S_IDLE)) state_nx = S_IDLE;
  end

  // The next pass's addresses are computed on the edge that enters S_NEXT.
  // They are therefore already valid in S_NEXT, and they stay put until the
  // next pass completes. more_passes records whether the pass that just
  // finished was the final one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ic               <= '0;
      oc               <= '0;
      num_ic           <= '0;
      num_oc           <= '0;
      x_base           <= '0;
      xstride          <= '0;
      ystride          <= '0;
      more_passes      <= 1'b0;
      param_waddr      <= '0;
      param_xaddr      <= '0;
      param_yaddr      <= '0;
      param_length_w   <= '0;
      param_width_in   <= '0;
      param_length_in  <= '0;
      param_length_out <= '0;
    end else if (accept) begin
      ic               <= '0;
      oc               <= '0;
      num_ic           <= cfg_num_ic;
      num_oc           <= cfg_num_oc;
      x_base           <= cfg_xaddr;
      xstride          <= cfg_xstride;
      ystride          <= cfg_ystride;
      more_passes      <= 1'b0;
      param_waddr      <= cfg_waddr;
      param_xaddr      <= cfg_xaddr;
      param_yaddr      <= cfg_yaddr;
      param_length_w   <= LEN_W;
      param_width_in   <= cfg_width_in;
      param_length_in  <= cfg_length_in;
      param_length_out <= cfg_length_out;
    end else if (advance) begin
      if (ic_last && oc_last) begin
        more_passes <= 1'b0;
      end else begin
        more_passes <= 1'b1;
        param_waddr <= param_waddr + W_STEP;
        if (ic_last) begin
          ic          <= '0;
          oc          <= oc + 8'd1;
          param_xaddr <= x_base;
          param_yaddr <= param_yaddr + ystride;
        end else begin
          ic          <= ic + 8'd1;
          param_xaddr <= param_xaddr + xstride;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv2d_sched.sv
// tb_conv2d_sched: directed, scoreboard-based bench for conv2d_sched.
//
// When a layer is started, its expected pass addresses are computed directly
// from the (oc, ic) closed-form formula and pushed onto a queue. Each observed
// prefetch/ena pops one entry from that queue and compares against it.
module tb_conv2d_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start, cfg_abort;
  logic [31:0] cfg_waddr, cfg_xaddr, cfg_yaddr, cfg_xstride, cfg_ystride;
  logic [8:0]  cfg_width_in;
  logic [17:0] cfg_length_in, cfg_length_out;
  logic [7:0]  cfg_num_ic, cfg_num_oc;
  logic        cfg_busy, cfg_done;
  logic        param_prefetch, param_ena;
  logic [31:0] param_waddr, param_xaddr, param_yaddr;
  logic [7:0]  param_length_w;
  logic [8:0]  param_width_in;
  logic [17:0] param_length_in, param_length_out;
  logic        wload_done, pass_done;

  conv2d_sched #(.KS(3), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_waddr(cfg_waddr), .cfg_xaddr(cfg_xaddr), .cfg_yaddr(cfg_yaddr),
    .cfg_xstride(cfg_xstride), .cfg_ystride(cfg_ystride),
    .cfg_width_in(cfg_width_in), .cfg_length_in(cfg_length_in),
    .cfg_length_out(cfg_length_out),
    .cfg_num_ic(cfg_num_ic), .cfg_num_oc(cfg_num_oc),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .param_prefetch(param_prefetch), .param_waddr(param_waddr),
    .param_length_w(param_length_w),
    .param_ena(param_ena), .param_xaddr(param_xaddr), .param_yaddr(param_yaddr),
    .param_width_in(param_width_in), .param_length_in(param_length_in),
    .param_length_out(param_length_out),
    .wload_done(wload_done), .pass_done(pass_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [31:0] x;
    logic [31:0] y;
  } pass_t;

  pass_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int pf_cnt = 0;
  int ena_cnt = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    if (param_prefetch) pf_cnt++;
    if (param_ena)      ena_cnt++;
    if (cfg_done)       done_cnt++;
  end

  task tick();
    @(negedge clk);
  endtask

  task checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit sel(input int which);
    case (which)
      0:       return param_prefetch;
      1:       return param_ena;
      2:       return cfg_done;
      default: return 1'b0;
    endcase
  endfunction

  task wait_for(input int which, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sel(which)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Drive a layer configuration, pulse cfg_start, and record the expected
  // passes. Returns at the negedge after the accepting edge.
  task applyStimulus(input logic [31:0] w, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] xs, input logic [31:0] ys,
                     input int nic, input int noc);
    pass_t e;
    cfg_waddr   = w;
    cfg_xaddr   = x;
    cfg_yaddr   = y;
    cfg_xstride = xs;
    cfg_ystride = ys;
    cfg_num_ic  = 8'(nic);
    cfg_num_oc  = 8'(noc);
    for (int o = 0; o < noc; o++) begin
      for (int i = 0; i < nic; i++) begin
        e.w = w + 32'((o * nic + i) * 36);
        e.x = x + 32'(i) * xs;
        e.y = y + 32'(o) * ys;
        exp_q.push_back(e);
      end
    end
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // Serve one pass: check the prefetch, answer with wload_done, check the ena,
  // and optionally finish the pass with pass_done. Without finish it returns
  // while the DUT sits in S_WAIT_P.
  task serve_pass(input bit spurious, input bit finish);
    pass_t e;
    bit    found;
    wait_for(0, 6, found);
    checkOutput("prefetch_seen", 64'(found), 64'd1);
    if (!found) return;
    checkOutput("sb_pending", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    checkOutput("param_waddr", 64'(param_waddr), 64'(e.w));
    checkOutput("param_length_w", 64'(param_length_w), 64'd9);
    tick();
    checkOutput("prefetch_single", 64'(param_prefetch), 64'd0);
    if (spurious) begin
      pass_done = 1'b1;
      cfg_start = 1'b1;
      cfg_xaddr = 32'hDEAD_0000;
      tick();
      pass_done = 1'b0;
      cfg_start = 1'b0;
      checkOutput("spurious_no_ena", 64'(param_ena), 64'd0);
      checkOutput("spurious_busy", 64'(cfg_busy), 64'd1);
      tick();
      checkOutput("spurious_still_wait", 64'(param_ena | param_prefetch), 64'd0);
    end
    wload_done = 1'b1;
    tick();
    wload_done = 1'b0;
    wait_for(1, 4, found);
    checkOutput("ena_seen", 64'(found), 64'd1);
    checkOutput("param_xaddr", 64'(param_xaddr), 64'(e.x));
    checkOutput("param_yaddr", 64'(param_yaddr), 64'(e.y));
    checkOutput("param_width_in", 64'(param_width_in), 64'd28);
    checkOutput("param_length_in", 64'(param_length_in), 64'd784);
    checkOutput("param_length_out", 64'(param_length_out), 64'd676);
    tick();
    checkOutput("ena_single", 64'(param_ena), 64'd0);
    if (finish) begin
      pass_done = 1'b1;
      tick();
      pass_done = 1'b0;
    end
  endtask

  task wait_done(input int budget);
    bit found;
    wait_for(2, budget, found);
    checkOutput("done_seen", 64'(found), 64'd1);
    if (found) begin
      tick();
      checkOutput("done_single", 64'(cfg_done), 64'd0);
      checkOutput("busy_after_done", 64'(cfg_busy), 64'd0);
    end
  endtask

  initial begin
    int pf0, ena0, done0;
    rst = 1'b1;
    cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_waddr = '0; cfg_xaddr = '0; cfg_yaddr = '0;
    cfg_xstride = '0; cfg_ystride = '0;
    cfg_width_in = 9'd28; cfg_length_in = 18'd784; cfg_length_out = 18'd676;
    cfg_num_ic = '0; cfg_num_oc = '0;
    wload_done = 1'b0; pass_done = 1'b0;
    repeat (3) tick();
    checkOutput("rst_busy", 64'(cfg_busy), 64'd0);
    checkOutput("rst_done", 64'(cfg_done), 64'd0);
    checkOutput("rst_prefetch", 64'(param_prefetch), 64'd0);
    checkOutput("rst_ena", 64'(param_ena), 64'd0);
    checkOutput("rst_waddr", 64'(param_waddr), 64'd0);
    checkOutput("rst_xaddr", 64'(param_xaddr), 64'd0);
    checkOutput("rst_yaddr", 64'(param_yaddr), 64'd0);
    checkOutput("rst_length_w", 64'(param_length_w), 64'd0);
    checkOutput("rst_length_in", 64'(param_length_in), 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] single pass");
    pf0 = pf_cnt; ena0 = ena_cnt; done0 = done_cnt;
    applyStimulus(32'h1000, 32'h2000, 32'h3000, 32'h400, 32'h800, 1, 1);
    checkOutput("busy_after_start", 64'(cfg_busy), 64'd1);
    serve_pass(1'b0, 1'b1);
    wait_done(4);
    checkOutput("single_pf_count", 64'(pf_cnt - pf0), 64'd1);
    checkOutput("single_ena_count", 64'(ena_cnt - ena0), 64'd1);
    checkOutput("single_done_count", 64'(done_cnt - done0), 64'd1);

    $display("[TB] multi-channel 2x2");
    pf0 = pf_cnt; done0 = done_cnt;
    applyStimulus(32'h1000, 32'h2000, 32'h3000, 32'h400, 32'h800, 2, 2);
    for (int p = 0; p < 4; p++) serve_pass(1'b0, 1'b1);
    wait_done(4);
    checkOutput("multi_pf_count", 64'(pf_cnt - pf0), 64'd4);
    checkOutput("multi_done_count", 64'(done_cnt - done0), 64'd1);

    $display("[TB] zero output channels");
    pf0 = pf_cnt; ena0 = ena_cnt;
    applyStimulus(32'h1000, 32'h2000, 32'h3000, 32'h400, 32'h800, 2, 0);
    wait_done(3);
    checkOutput("zero_pf_count", 64'(pf_cnt - pf0), 64'd0);
    checkOutput("zero_ena_count", 64'(ena_cnt - ena0), 64'd0);

    $display("[TB] abort in pass 2, then restart");
    pf0 = pf_cnt; done0 = done_cnt;
    applyStimulus(32'h1000, 32'h2000, 32'h3000, 32'h400, 32'h800, 2, 2);
    serve_pass(1'b0, 1'b1);
    serve_pass(1'b0, 1'b0);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    checkOutput("abort_busy", 64'(cfg_busy), 64'd0);
    checkOutput("abort_done", 64'(cfg_done), 64'd0);
    checkOutput("abort_strobes", 64'(param_prefetch | param_ena), 64'd0);
    repeat (4) tick();
    checkOutput("abort_no_done", 64'(done_cnt - done0), 64'd0);
    checkOutput("abort_pf_count", 64'(pf_cnt - pf0), 64'd2);
    exp_q.delete();
    applyStimulus(32'h5000, 32'h6000, 32'h7000, 32'h100, 32'h200, 2, 1);
    serve_pass(1'b0, 1'b1);
    serve_pass(1'b0, 1'b1);
    wait_done(4);

    $display("[TB] spurious handshakes");
    pf0 = pf_cnt; ena0 = ena_cnt;
    applyStimulus(32'h1000, 32'h2000, 32'h3000, 32'h400, 32'h800, 1, 1);
    serve_pass(1'b1, 1'b1);
    wait_done(4);
    checkOutput("spurious_pf_count", 64'(pf_cnt - pf0), 64'd1);
    checkOutput("spurious_ena_count", 64'(ena_cnt - ena0), 64'd1);

    $display("[TB] weight address wrap");
    applyStimulus(32'hFFFF_FFF0, 32'h2000, 32'h3000, 32'h400, 32'h800, 2, 1);
    serve_pass(1'b0, 1'b1);
    serve_pass(1'b0, 1'b1);
    wait_done(4);

    $display("[TB] reset mid-layer");
    done0 = done_cnt;
    applyStimulus(32'h1000, 32'h2000, 32'h3000, 32'h400, 32'h800, 1, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", 64'(cfg_busy), 64'd0);
    checkOutput("midrst_waddr", 64'(param_waddr), 64'd0);
    checkOutput("midrst_length_w", 64'(param_length_w), 64'd0);
    wload_done = 1'b1;
    tick();
    wload_done = 1'b0;
    repeat (3) tick();
    checkOutput("midrst_no_done", 64'(done_cnt - done0), 64'd0);
    checkOutput("midrst_idle", 64'(cfg_busy | param_ena | param_prefetch), 64'd0);
    exp_q.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
